ddr3_ui_arbiter: RTL and testbench

Two-port round-robin arbiter that shares a single MIG DDR3 user-interface (UI) command/write-data port between two requesters (e.g. a host-side write client and a readback client). It serializes one BL8 command at a time onto the UI, issues the single 256-bit write beat ahead of each write command, and routes each returning read beat to the requester that issued it using an in-order tag FIFO. It sits directly between the requester logic and the MIG UI.

---
 rtl/ddr3_ui_arbiter_if.sv | 24 ++
 rtl/ddr3_ui_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ddr3_ui_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_ui_arbiter_if.sv
// Requester-side handshake bundle for the DDR3 UI arbiter: one command
// channel in, an accept strobe and a registered read-return channel out.
interface ddr3_ui_arbiter_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 256
);
  logic                  valid;
  logic [2:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output valid, cmd, addr, wdata,
    input  ack, rd_valid, rd_data
  );

  modport slave (
    input  valid, cmd, addr, wdata,
    output ack, rd_valid, rd_data
  );
endinterface

// File: rtl/ddr3_ui_arbiter.sv
// Two-port round-robin arbiter in front of a MIG DDR3 UI port: one BL8 command
// at a time, write beat ahead of its command, in-order tag FIFO for read returns.
//
// state  | meaning
// IDLE   | waiting for calib_done and an eligible requester
// WDATA  | presenting the write beat until app_wdf_rdy
// CMD    | presenting the command until app_rdy; ack fires on acceptance
module ddr3_ui_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 256,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          calib_done,
  ddr3_ui_arbiter_if.slave              r0,
  ddr3_ui_arbiter_if.slave              r1,
  input  logic                          app_rdy,
  input  logic                          app_wdf_rdy,
  input  logic                          app_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]         app_rd_data,
  output logic                          app_en,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [DATA_WIDTH-1:0]         app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]       app_wdf_mask,
  output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
  output logic                          err_tag
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_CMD} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  en_q, en_d;
  logic                  wren_q, wren_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [TAG_DEPTH-1:0]  tag_q, tag_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  rdv0_q, rdv0_d;
  logic                  rdv1_q, rdv1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  elig0, elig1, pick, accept, push, pop, pop_tag;
  logic [2:0]            sel_cmd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    elig0     = r0.valid && ((r0.cmd == CMD_WR) || (cnt_q < FULL));
    elig1     = r1.valid && ((r1.cmd == CMD_WR) || (cnt_q < FULL));
    // With both eligible the one not granted last wins; otherwise the lone one.
    pick      = (elig0 && elig1) ? ~last_q : elig1;
    sel_cmd   = pick ? r1.cmd   : r0.cmd;
    sel_addr  = pick ? r1.addr  : r0.addr;
    sel_wdata = pick ? r1.wdata : r0.wdata;
    accept    = (state_q == S_CMD) && app_rdy;
    push      = accept && (cmd_q == CMD_RD);
    pop       = app_rd_data_valid && (cnt_q != '0);
    pop_tag   = tag_q[rptr_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    en_d    = en_q;
    wren_d  = wren_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (calib_done && (elig0 || elig1)) begin
          grant_d = pick;
          last_d  = pick;
          cmd_d   = (sel_cmd == CMD_WR) ? CMD_WR : CMD_RD;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_cmd == CMD_WR) begin
            state_d = S_WDATA;
            wren_d  = 1'b1;
          end else begin
            state_d = S_CMD;
            en_d    = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (app_wdf_rdy) begin
          state_d = S_CMD;
          wren_d  = 1'b0;
          en_d    = 1'b1;
        end
      end
      S_CMD: begin
        if (app_rdy) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        wren_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      tag_d[wptr_q] = grant_q;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    rdv0_d  = pop && !pop_tag;
    rdv1_d  = pop && pop_tag;
    rdata_d = pop ? app_rd_data : rdata_q;
    // Data with no tag to route it has nowhere to go; drop it and flag.
    err_d   = err_q || (app_rd_data_valid && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdv0_q  <= 1'b0;
      rdv1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      en_q    <= en_d;
      wren_q  <= wren_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdv0_q  <= rdv0_d;
      rdv1_q  <= rdv1_d;
      rdata_q <= rdata_d;
    end
  end

  assign app_en         = en_q;
  assign app_wdf_wren   = wren_q;
  assign app_wdf_end    = wren_q;
  assign app_cmd        = cmd_q;
  assign app_addr       = addr_q;
  assign app_wdf_data   = wdata_q;
  assign app_wdf_mask   = '0;
  assign rd_outstanding = cnt_q;
  assign err_tag        = err_q;

  assign r0.ack      = accept && !grant_q;
  assign r1.ack      = accept && grant_q;
  assign r0.rd_valid = rdv0_q;
  assign r1.rd_valid = rdv1_q;
  assign r0.rd_data  = rdata_q;
  assign r1.rd_data  = rdata_q;

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Scenario tasks plus a randomized run checked against a queue-based model of
// request acceptance and in-order read return.
module tb_ddr3_ui_arbiter;
  localparam int AW = 30;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          reset, calib_done, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [DW-1:0] app_rd_data;
  logic          app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic [4:0]    rd_outstanding;
  logic          err_tag;
  int            total = 0;
  int            bad   = 0;

  ddr3_ui_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i0 ();
  ddr3_ui_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i1 ();

  ddr3_ui_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .r0(i0), .r1(i1),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .app_en(app_en), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .rd_outstanding(rd_outstanding), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i0.valid = 1'b0; i0.cmd = 3'd0; i0.addr = '0; i0.wdata = '0;
    i1.valid = 1'b0; i1.cmd = 3'd0; i1.addr = '0; i1.wdata = '0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    calib_done = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    calib_done = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    i0.valid = 1'b1; i1.valid = 1'b1; i1.cmd = 3'd1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    total++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b000) begin bad++; $display("FAIL reset_strobes got %b want 000", {app_en, app_wdf_wren, app_wdf_end}); end
    total++; if (app_cmd !== 3'd0 || app_addr !== '0 || app_wdf_data !== '0) begin bad++; $display("FAIL reset_bus got cmd=%0h addr=%0h want 0", app_cmd, app_addr); end
    total++; if (app_wdf_mask !== '0) begin bad++; $display("FAIL reset_mask got %0h want 0", app_wdf_mask); end
    total++; if (rd_outstanding !== 5'd0 || err_tag !== 1'b0) begin bad++; $display("FAIL reset_fifo got cnt=%0d err=%b want 0 0", rd_outstanding, err_tag); end
    total++; if ({i0.ack, i1.ack, i0.rd_valid, i1.rd_valid} !== 4'b0000) begin bad++; $display("FAIL reset_req got %b want 0000", {i0.ack, i1.ack, i0.rd_valid, i1.rd_valid}); end
    total++; if (i0.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %0h want 0", i0.rd_data); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d;
    d = {32{8'hA5}};
    do_reset();
    i0.valid = 1'b1; i0.cmd = 3'b000; i0.addr = 30'h40; i0.wdata = d;
    #1;
    total++; if (app_wdf_wren !== 1'b0 || app_en !== 1'b0) begin bad++; $display("FAIL wr_T got wren=%b en=%b want 0 0", app_wdf_wren, app_en); end
    next_cycle(); #1;
    total++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_en !== 1'b0) begin bad++; $display("FAIL wr_T1_strobes got wren=%b end=%b en=%b want 1 1 0", app_wdf_wren, app_wdf_end, app_en); end
    total++; if (app_wdf_data !== d) begin bad++; $display("FAIL wr_T1_data got %0h want %0h", app_wdf_data, d); end
    next_cycle(); #1;
    total++; if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 30'h40) begin bad++; $display("FAIL wr_T2_cmd got en=%b cmd=%0h addr=%0h want 1 0 40", app_en, app_cmd, app_addr); end
    total++; if (i0.ack !== 1'b1 || i1.ack !== 1'b0 || app_wdf_wren !== 1'b0) begin bad++; $display("FAIL wr_T2_ack got ack0=%b ack1=%b wren=%b want 1 0 0", i0.ack, i1.ack, app_wdf_wren); end
    next_cycle();
    i0.valid = 1'b0;
    #1;
    total++; if (app_en !== 1'b0 || i0.ack !== 1'b0) begin bad++; $display("FAIL wr_T3 got en=%b ack=%b want 0 0", app_en, i0.ack); end
  endtask

  task automatic test_alternating_reads();
    int order[$];
    int n0, n1, cyc;
    bit a0, a1;
    logic [DW-1:0] d[4];
    n0 = 0; n1 = 0; cyc = 0;
    do_reset();
    i0.valid = 1'b1; i0.cmd = 3'd1; i0.addr = 30'h100;
    i1.valid = 1'b1; i1.cmd = 3'd1; i1.addr = 30'h200;
    while (cyc < 40 && order.size() < 4) begin
      #1;
      a0 = i0.ack; a1 = i1.ack;
      if (a0) begin
        order.push_back(0);
        total++; if (app_addr !== 30'h100 + AW'(n0)) begin bad++; $display("FAIL alt_addr0 got %0h want %0h", app_addr, 30'h100 + n0); end
      end
      if (a1) begin
        order.push_back(1);
        total++; if (app_addr !== 30'h200 + AW'(n1)) begin bad++; $display("FAIL alt_addr1 got %0h want %0h", app_addr, 30'h200 + n1); end
      end
      next_cycle();
      if (a0) begin n0++; i0.addr = 30'h100 + AW'(n0); if (n0 == 2) i0.valid = 1'b0; end
      if (a1) begin n1++; i1.addr = 30'h200 + AW'(n1); if (n1 == 2) i1.valid = 1'b0; end
      cyc++;
    end
    i0.valid = 1'b0; i1.valid = 1'b0;
    total++; if (order.size() != 4) begin bad++; $display("FAIL alt_timeout got %0d grants want 4", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      total++; if (order[k] != (k % 2)) begin bad++; $display("FAIL alt_order[%0d] got r%0d want r%0d", k, order[k], k % 2); end
    end
    total++; if (rd_outstanding !== 5'd4) begin bad++; $display("FAIL alt_outstanding got %0d want 4", rd_outstanding); end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      d[k] = rand_beat();
      app_rd_data_valid = 1'b1; app_rd_data = d[k];
      next_cycle();
      if (k == 3 || k == order.size() - 1) app_rd_data_valid = 1'b0;
      total++; if (i0.rd_valid !== (order[k] == 0) || i1.rd_valid !== (order[k] == 1)) begin bad++; $display("FAIL alt_route[%0d] got v0=%b v1=%b want r%0d", k, i0.rd_valid, i1.rd_valid, order[k]); end
      total++; if ((order[k] == 0 ? i0.rd_data : i1.rd_data) !== d[k]) begin bad++; $display("FAIL alt_data[%0d] got %0h want %0h", k, (order[k] == 0 ? i0.rd_data : i1.rd_data), d[k]); end
    end
    app_rd_data_valid = 1'b0;
    next_cycle(); #1;
    total++; if (rd_outstanding !== 5'd0 || i0.rd_valid !== 1'b0 || i1.rd_valid !== 1'b0) begin bad++; $display("FAIL alt_drain got cnt=%0d v0=%b v1=%b want 0 0 0", rd_outstanding, i0.rd_valid, i1.rd_valid); end
  endtask

  task automatic test_cmd_stall();
    do_reset();
    app_rdy = 1'b0;
    i1.valid = 1'b1; i1.cmd = 3'd1; i1.addr = 30'h1234567;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (app_en !== 1'b1 || app_addr !== 30'h1234567 || app_cmd !== 3'b001) begin bad++; $display("FAIL stall_hold[%0d] got en=%b addr=%0h cmd=%0h want 1 1234567 1", k, app_en, app_addr, app_cmd); end
      total++; if (i1.ack !== 1'b0 || i0.ack !== 1'b0) begin bad++; $display("FAIL stall_noack[%0d] got %b%b want 00", k, i0.ack, i1.ack); end
      next_cycle();
    end
    app_rdy = 1'b1;
    #1;
    total++; if (i1.ack !== 1'b1 || i0.ack !== 1'b0 || app_en !== 1'b1) begin bad++; $display("FAIL stall_ack got ack1=%b ack0=%b en=%b want 1 0 1", i1.ack, i0.ack, app_en); end
    next_cycle();
    i1.valid = 1'b0;
    #1;
    total++; if (app_en !== 1'b0 || rd_outstanding !== 5'd1) begin bad++; $display("FAIL stall_after got en=%b cnt=%0d want 0 1", app_en, rd_outstanding); end
  endtask

  task automatic test_fifo_full();
    int acks, cyc;
    bit got, a;
    logic [DW-1:0] d;
    acks = 0; cyc = 0;
    do_reset();
    i0.valid = 1'b1; i0.cmd = 3'd1; i0.addr = '0;
    while (acks < 16 && cyc < 80) begin
      #1;
      a = i0.ack;
      if (a) acks++;
      next_cycle();
      if (a) i0.addr = i0.addr + AW'(1);
      cyc++;
    end
    total++; if (acks != 16) begin bad++; $display("FAIL full_fill got %0d acks want 16", acks); end
    total++; if (rd_outstanding !== 5'd16) begin bad++; $display("FAIL full_count got %0d want 16", rd_outstanding); end
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (app_en !== 1'b0 || i0.ack !== 1'b0) begin bad++; $display("FAIL full_blocked[%0d] got en=%b ack=%b want 0 0", k, app_en, i0.ack); end
      next_cycle();
    end
    i1.valid = 1'b1; i1.cmd = 3'd0; i1.addr = 30'h77; i1.wdata = rand_beat();
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (i1.ack) begin
        got = 1'b1;
        total++; if (app_cmd !== 3'b000 || app_addr !== 30'h77) begin bad++; $display("FAIL full_wr_cmd got cmd=%0h addr=%0h want 0 77", app_cmd, app_addr); end
      end
      next_cycle();
    end
    i1.valid = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL full_wr_grant got no ack want ack"); end
    d = rand_beat();
    app_rd_data_valid = 1'b1; app_rd_data = d;
    next_cycle();
    app_rd_data_valid = 1'b0;
    total++; if (i0.rd_valid !== 1'b1 || i1.rd_valid !== 1'b0 || i0.rd_data !== d) begin bad++; $display("FAIL full_pop got v0=%b v1=%b want 1 0 with data", i0.rd_valid, i1.rd_valid); end
    total++; if (rd_outstanding !== 5'd15) begin bad++; $display("FAIL full_15 got %0d want 15", rd_outstanding); end
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      #1;
      if (i0.ack) got = 1'b1;
      next_cycle();
    end
    i0.valid = 1'b0;
    total++; if (!got || rd_outstanding !== 5'd16) begin bad++; $display("FAIL full_regrant got ack=%b cnt=%0d want 1 16", got, rd_outstanding); end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    app_rd_data_valid = 1'b1; app_rd_data = rand_beat();
    next_cycle();
    app_rd_data_valid = 1'b0;
    total++; if (i0.rd_valid !== 1'b0 || i1.rd_valid !== 1'b0) begin bad++; $display("FAIL err_no_route got v0=%b v1=%b want 0 0", i0.rd_valid, i1.rd_valid); end
    total++; if (err_tag !== 1'b1 || rd_outstanding !== 5'd0) begin bad++; $display("FAIL err_set got err=%b cnt=%0d want 1 0", err_tag, rd_outstanding); end
    next_cycle();
    total++; if (err_tag !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err_tag); end
    app_wdf_rdy = 1'b0;
    i0.valid = 1'b1; i0.cmd = 3'd0; i0.addr = 30'h55; i0.wdata = rand_beat();
    next_cycle(); #1;
    total++; if (app_wdf_wren !== 1'b1) begin bad++; $display("FAIL err_wdata_stall got wren=%b want 1", app_wdf_wren); end
    reset = 1'b1;
    next_cycle(); #1;
    total++; if ({app_en, app_wdf_wren, app_wdf_end, err_tag} !== 4'b0000) begin bad++; $display("FAIL rst_mid_strobes got %b want 0000", {app_en, app_wdf_wren, app_wdf_end, err_tag}); end
    total++; if (app_cmd !== 3'd0 || app_addr !== '0 || app_wdf_data !== '0 || i0.ack !== 1'b0) begin bad++; $display("FAIL rst_mid_bus got cmd=%0h addr=%0h ack=%b want 0", app_cmd, app_addr, i0.ack); end
    reset = 1'b0; app_wdf_rdy = 1'b1;
    i0.valid = 1'b0;
    i1.valid = 1'b1; i1.cmd = 3'd1; i1.addr = 30'h9;
    next_cycle();
    next_cycle();
    i1.valid = 1'b0;
    total++; if (rd_outstanding !== 5'd1) begin bad++; $display("FAIL rst_rd_issue got %0d want 1", rd_outstanding); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    app_rd_data_valid = 1'b1; app_rd_data = rand_beat();
    next_cycle();
    app_rd_data_valid = 1'b0;
    total++; if (i1.rd_valid !== 1'b0 || err_tag !== 1'b1) begin bad++; $display("FAIL rst_stray got v1=%b err=%b want 0 1", i1.rd_valid, err_tag); end
  endtask

  task automatic test_random();
    int q[$];
    bit ak0, ak1, e0, e1, bs, gen, done;
    logic [DW-1:0] ed, lb;
    int nack, p;
    ak0 = 0; ak1 = 0; e0 = 0; e1 = 0; bs = 0; done = 0; ed = '0; lb = '0; nack = 0;
    do_reset();
    for (int cyc = 0; cyc < 900 && !done; cyc++) begin
      if (cyc > 0) begin
        total++; if (i0.rd_valid !== e0 || i1.rd_valid !== e1) begin bad++; $display("FAIL rnd_route cyc %0d got %b%b want %b%b", cyc, i0.rd_valid, i1.rd_valid, e0, e1); end
        if (e0 || e1) begin
          total++; if ((e0 ? i0.rd_data : i1.rd_data) !== ed) begin bad++; $display("FAIL rnd_rd_data cyc %0d got %0h want %0h", cyc, (e0 ? i0.rd_data : i1.rd_data), ed); end
        end
        total++; if (int'(rd_outstanding) != q.size()) begin bad++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, rd_outstanding, q.size()); end
      end
      gen = (cyc < 600);
      if (ak0) i0.valid = 1'b0;
      if (ak1) i1.valid = 1'b0;
      if (gen && !i0.valid && ($urandom % 3 == 0)) begin
        i0.valid = 1'b1; i0.cmd = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        i0.addr = AW'($urandom()); i0.wdata = rand_beat();
      end
      if (gen && !i1.valid && ($urandom % 3 == 0)) begin
        i1.valid = 1'b1; i1.cmd = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        i1.addr = AW'($urandom()); i1.wdata = rand_beat();
      end
      app_rdy     = gen ? ($urandom % 4 != 0) : 1'b1;
      app_wdf_rdy = gen ? ($urandom % 4 != 0) : 1'b1;
      calib_done  = gen ? ($urandom % 16 != 0) : 1'b1;
      e0 = 0; e1 = 0;
      if (q.size() > 0 && ($urandom % 2 == 0 || !gen)) begin
        p = q.pop_front();
        ed = rand_beat();
        app_rd_data_valid = 1'b1; app_rd_data = ed;
        e0 = (p == 0); e1 = (p == 1);
      end else begin
        app_rd_data_valid = 1'b0;
      end
      #1;
      ak0 = i0.ack; ak1 = i1.ack;
      total++; if (ak0 && ak1) begin bad++; $display("FAIL rnd_double_ack cyc %0d got 11 want at most one", cyc); end
      if (app_wdf_wren && app_wdf_rdy) begin lb = app_wdf_data; bs = 1; end
      if (ak0) begin
        nack++;
        total++; if (app_en !== 1'b1 || app_addr !== i0.addr || app_cmd !== ((i0.cmd == 3'd0) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL rnd_cmd0 cyc %0d got en=%b addr=%0h cmd=%0h want addr=%0h", cyc, app_en, app_addr, app_cmd, i0.addr); end
        if (i0.cmd == 3'd0) begin
          total++; if (!bs || lb !== i0.wdata) begin bad++; $display("FAIL rnd_wbeat0 cyc %0d got seen=%b want write beat", cyc, bs); end
          bs = 0;
        end else q.push_back(0);
      end
      if (ak1) begin
        nack++;
        total++; if (app_en !== 1'b1 || app_addr !== i1.addr || app_cmd !== ((i1.cmd == 3'd0) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL rnd_cmd1 cyc %0d got en=%b addr=%0h cmd=%0h want addr=%0h", cyc, app_en, app_addr, app_cmd, i1.addr); end
        if (i1.cmd == 3'd0) begin
          total++; if (!bs || lb !== i1.wdata) begin bad++; $display("FAIL rnd_wbeat1 cyc %0d got seen=%b want write beat", cyc, bs); end
          bs = 0;
        end else q.push_back(1);
      end
      if (!gen && !ak0 && !ak1 && !i0.valid && !i1.valid && q.size() == 0 && !app_rd_data_valid) done = 1;
      next_cycle();
    end
    app_rd_data_valid = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL rnd_timeout got unfinished traffic want drained"); end
    total++; if (nack < 20) begin bad++; $display("FAIL rnd_progress got %0d acks want >=20", nack); end
    total++; if (rd_outstanding !== 5'd0 || err_tag !== 1'b0) begin bad++; $display("FAIL rnd_final got cnt=%0d err=%b want 0 0", rd_outstanding, err_tag); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_alternating_reads();
    test_cmd_stall();
    test_fifo_full();
    test_err_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
